// File: rtl/aes_out_serializer.sv
// aes_out_serializer
// Captures 128-bit AES result blocks on a rising edge of AES_data_out_valid,
// buffers up to BUF_BLOCKS of them and streams each one out as four 32-bit
// words (most-significant word first) over a valid/ready handshake.
// Optional feature macro: AES_SER_PARITY_EN adds the ser_par output
// (XOR-reduce of ser_word, registered alongside it).
module aes_out_serializer #(
  parameter int BUF_BLOCKS = 2
) (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_data_out_valid,
  input  logic [127:0] AES_data_out,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic [31:0]  ser_word,
  output logic         ser_last,
  output logic [1:0]   ser_idx,
  output logic [2:0]   buf_level,
  output logic         ovf_err,
  output logic [15:0]  blk_cnt
`ifdef AES_SER_PARITY_EN
  ,
  output logic         ser_par
`endif
);

  // Pointer width: 1 bit for 2 entries, 2 bits for 4 entries.
  localparam int PW = (BUF_BLOCKS > 2) ? 2 : 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
  localparam logic [2:0]    BUF_LVL = 3'(BUF_BLOCKS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Even parity of a 32-bit word.
  function automatic logic parity32(input logic [31:0] w);
    parity32 = ^w;
  endfunction

  // Word k of a block, word 0 being the most significant.
  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] k);
    case (k)
      2'd0:    word_sel = blk[127:96];
      2'd1:    word_sel = blk[95:64];
      2'd2:    word_sel = blk[63:32];
      2'd3:    word_sel = blk[31:0];
      default: word_sel = blk[127:96];
    endcase
  endfunction

  // State
  state_e         state_q, state_d;
  logic           prev_valid_q, prev_valid_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]     level_q, level_d;
  logic           ser_valid_q, ser_valid_d;
  logic [31:0]    ser_word_q, ser_word_d;
  logic [1:0]     ser_idx_q, ser_idx_d;
  logic           ser_last_q, ser_last_d;
  logic           ovf_q, ovf_d;
  logic [15:0]    blk_cnt_q, blk_cnt_d;
  logic           ser_par_q, ser_par_d;
  logic [127:0]   mem_q [BUF_BLOCKS];

  // Combinational helpers
  logic           cap_s;
  logic           hs_s;
  logic           pop_s;
  logic           accept_s;
  logic [127:0]   head_next_s;

  // Rising-edge detect on the result-valid strobe.
  always_comb begin
    prev_valid_d = AES_data_out_valid;
    cap_s        = AES_data_out_valid & ~prev_valid_q;
  end

  // Buffer bookkeeping: pop on the final-word handshake, push on capture if a slot is (or becomes) free.
  always_comb begin
    hs_s      = ser_valid_q & ser_ready;
    pop_s     = hs_s & (ser_idx_q == 2'd3);
    accept_s  = cap_s & ((level_q != BUF_LVL) | pop_s);
    wr_ptr_d  = accept_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d  = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    level_d   = level_q + {2'b00, accept_s} - {2'b00, pop_s};
    ovf_d     = ovf_q | (cap_s & ~accept_s);
    blk_cnt_d = blk_cnt_q + {15'd0, pop_s};
    // The incoming block becomes the head straight away when nothing else remains queued.
    if (accept_s && (wr_ptr_q == rd_ptr_d)) begin
      head_next_s = AES_data_out;
    end else begin
      head_next_s = mem_q[rd_ptr_d];
    end
  end

  // State register plus all registered outputs and buffer control.
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q      <= ST_IDLE;
      prev_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= 3'd0;
      ser_valid_q  <= 1'b0;
      ser_word_q   <= 32'd0;
      ser_idx_q    <= 2'd0;
      ser_last_q   <= 1'b0;
      ovf_q        <= 1'b0;
      blk_cnt_q    <= 16'd0;
      ser_par_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_valid_q <= prev_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ser_valid_q  <= ser_valid_d;
      ser_word_q   <= ser_word_d;
      ser_idx_q    <= ser_idx_d;
      ser_last_q   <= ser_last_d;
      ovf_q        <= ovf_d;
      blk_cnt_q    <= blk_cnt_d;
      ser_par_q    <= ser_par_d;
    end
  end

  // Block storage write port; contents need no reset since the pointers define validity.
  always_ff @(posedge AES_clk) begin
    if (!AES_rst && accept_s) begin
      mem_q[wr_ptr_q] <= AES_data_out;
    end
  end

  // Next-state logic: send while any block is held, idle otherwise.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (level_d != 3'd0) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (pop_s) begin
          state_d = (level_d != 3'd0) ? ST_SEND : ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: word index advance and the word presented in the next cycle.
  always_comb begin
    ser_idx_d = 2'd0;
    case (state_q)
      ST_IDLE: ser_idx_d = 2'd0;
      ST_SEND: begin
        if (hs_s) begin
          ser_idx_d = pop_s ? 2'd0 : (ser_idx_q + 2'd1);
        end else begin
          ser_idx_d = ser_idx_q;
        end
      end
      default: ser_idx_d = 2'd0;
    endcase
    ser_valid_d = (state_d == ST_SEND);
    if (state_d == ST_SEND) begin
      ser_word_d = word_sel(head_next_s, ser_idx_d);
      ser_last_d = (ser_idx_d == 2'd3);
    end else begin
      ser_word_d = ser_word_q;
      ser_last_d = 1'b0;
    end
    ser_par_d = parity32(ser_word_d);
  end

  assign ser_valid = ser_valid_q;
  assign ser_word  = ser_word_q;
  assign ser_idx   = ser_idx_q;
  assign ser_last  = ser_last_q;
  assign buf_level = level_q;
  assign ovf_err   = ovf_q;
  assign blk_cnt   = blk_cnt_q;
`ifdef AES_SER_PARITY_EN
  assign ser_par   = ser_par_q;
`else
  // Parity flop has no consumer in this build; fold it into a dead sink.
  logic unused_par_s;
  assign unused_par_s = ser_par_q;
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// Self-checking bench for aes_out_serializer: directed scenarios plus a random
// phase, all checked each cycle against a queue-based reference model.
module tb_aes_out_serializer;

  localparam int BUF = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         v;
  logic [127:0] din;
  logic         ready;
  logic         ser_valid;
  logic [31:0]  ser_word;
  logic         ser_last;
  logic [1:0]   ser_idx;
  logic [2:0]   buf_level;
  logic         ovf_err;
  logic [15:0]  blk_cnt;
`ifdef AES_SER_PARITY_EN
  logic         ser_par;
`endif

  always #5 clk = ~clk;

  aes_out_serializer #(.BUF_BLOCKS(BUF)) dut (
    .AES_clk(clk),
    .AES_rst(rst),
    .AES_data_out_valid(v),
    .AES_data_out(din),
    .ser_valid(ser_valid),
    .ser_ready(ready),
    .ser_word(ser_word),
    .ser_last(ser_last),
    .ser_idx(ser_idx),
    .buf_level(buf_level),
    .ovf_err(ovf_err),
    .blk_cnt(blk_cnt)
`ifdef AES_SER_PARITY_EN
    ,
    .ser_par(ser_par)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of held blocks, word index within head, flags.
  logic [127:0] mq[$];
  int           mk = 0;
  logic         movf = 1'b0;
  logic [15:0]  mcnt = 16'd0;
  logic         mprev = 1'b0;
  logic [31:0]  obs[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic r_st, input logic vv, input logic [127:0] d, input logic rd);
    logic cap;
    logic [127:0] hd;
    rst = r_st; v = vv; din = d; ready = rd;
    if (!r_st && ser_valid === 1'b1 && rd) obs.push_back(ser_word);
    @(posedge clk);
    if (r_st) begin
      mq.delete(); mk = 0; movf = 1'b0; mcnt = 16'd0; mprev = 1'b0;
    end else begin
      cap = vv && !mprev;
      mprev = vv;
      if (mq.size() > 0 && rd) begin
        if (mk == 3) begin
          void'(mq.pop_front()); mk = 0; mcnt = mcnt + 16'd1;
        end else begin
          mk++;
        end
      end
      if (cap) begin
        if (mq.size() < BUF) mq.push_back(d);
        else movf = 1'b1;
      end
    end
    #1;
    chk("valid", 32'(ser_valid), 32'(mq.size() > 0));
    chk("idx", 32'(ser_idx), 32'(mk));
    chk("last", 32'(ser_last), 32'(mq.size() > 0 && mk == 3));
    chk("level", 32'(buf_level), 32'(mq.size()));
    chk("ovf", 32'(ovf_err), 32'(movf));
    chk("blk_cnt", 32'(blk_cnt), 32'(mcnt));
    if (r_st) begin
      chk("rst_word", ser_word, 32'd0);
    end else if (mq.size() > 0) begin
      hd = mq[0];
      chk("word", ser_word, hd[127-32*mk -: 32]);
    end
`ifdef AES_SER_PARITY_EN
    if (r_st) chk("rst_par", 32'(ser_par), 32'd0);
    else if (mq.size() > 0) chk("par", 32'(ser_par), 32'(^ser_word));
`endif
  endtask

  localparam logic [127:0] T1 = 128'h3925841d_02dc09fb_dc118597_196a0b32;
  logic [31:0] t1w [4];

  initial begin
    t1w[0] = 32'h3925841d; t1w[1] = 32'h02dc09fb;
    t1w[2] = 32'hdc118597; t1w[3] = 32'h196a0b32;
    rst = 1'b1; v = 1'b0; din = 128'd0; ready = 1'b0;

    // Reset state
    cycle(1'b1, 1'b0, 128'd0, 1'b0);
    cycle(1'b1, 1'b0, 128'd0, 1'b0);

    // T1: single block, ready high
    obs.delete();
    cycle(1'b0, 1'b1, T1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 128'd0, 1'b1);
    chk("t1_count", 32'(obs.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs.size(); i++) chk("t1_word", obs[i], t1w[i]);
    chk("t1_blk_cnt", 32'(blk_cnt), 32'd1);

    // T3: backpressure on word 1 for 3 cycles
    obs.delete();
    cycle(1'b0, 1'b1, T1, 1'b1);
    cycle(1'b0, 1'b0, 128'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 128'd0, 1'b0);
      chk("t3_hold_word", ser_word, 32'h02dc09fb);
      chk("t3_hold_idx", 32'(ser_idx), 32'd1);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 128'd0, 1'b1);
    chk("t3_count", 32'(obs.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs.size(); i++) chk("t3_word", obs[i], t1w[i]);

    // T2: valid held for 51 cycles captures exactly one block
    obs.delete();
    for (int i = 0; i < 51; i++) cycle(1'b0, 1'b1, 128'h0123456789abcdef_fedcba9876543210, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 128'd0, 1'b1);
    chk("t2_count", 32'(obs.size()), 32'd4);
    chk("t2_ovf", 32'(ovf_err), 32'd0);

    // T5: full buffer, capture coincides with word-3 handshake
    cycle(1'b1, 1'b0, 128'd0, 1'b0);
    cycle(1'b0, 1'b1, {4{32'haaaa0001}}, 1'b0);
    cycle(1'b0, 1'b0, 128'd0, 1'b0);
    cycle(1'b0, 1'b1, {4{32'hbbbb0002}}, 1'b0);
    cycle(1'b0, 1'b0, 128'd0, 1'b1);
    cycle(1'b0, 1'b0, 128'd0, 1'b1);
    cycle(1'b0, 1'b0, 128'd0, 1'b1);
    cycle(1'b0, 1'b1, {4{32'hcccc0003}}, 1'b1);
    chk("t5_level", 32'(buf_level), 32'd2);
    chk("t5_ovf", 32'(ovf_err), 32'd0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 128'd0, 1'b1);

    // T4: overflow with ready low, then drain
    cycle(1'b1, 1'b0, 128'd0, 1'b0);
    obs.delete();
    cycle(1'b0, 1'b1, {4{32'h11111111}}, 1'b0);
    cycle(1'b0, 1'b0, 128'd0, 1'b0);
    cycle(1'b0, 1'b1, {4{32'h22222222}}, 1'b0);
    cycle(1'b0, 1'b0, 128'd0, 1'b0);
    cycle(1'b0, 1'b1, {4{32'h33333333}}, 1'b0);
    cycle(1'b0, 1'b0, 128'd0, 1'b0);
    chk("t4_level", 32'(buf_level), 32'd2);
    chk("t4_ovf", 32'(ovf_err), 32'd1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 128'd0, 1'b1);
    chk("t4_count", 32'(obs.size()), 32'd8);
    chk("t4_blk_cnt", 32'(blk_cnt), 32'd2);

    // T6: reset after word 1 accepted, then clean restart
    cycle(1'b1, 1'b0, 128'd0, 1'b0);
    cycle(1'b0, 1'b1, T1, 1'b1);
    cycle(1'b0, 1'b0, 128'd0, 1'b1);
    cycle(1'b1, 1'b0, 128'd0, 1'b1);
    obs.delete();
    cycle(1'b0, 1'b1, T1, 1'b1);
    chk("t6_idx0", 32'(ser_idx), 32'd0);
    chk("t6_word0", ser_word, 32'h3925841d);
`ifdef AES_SER_PARITY_EN
    chk("t6_par", 32'(ser_par), 32'd1);
`endif
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 128'd0, 1'b1);

    // Valid already high as reset is released counts as a rising edge
    cycle(1'b1, 1'b1, {4{32'h5a5a5a5a}}, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, {4{32'h5a5a5a5a}}, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 128'd0, 1'b1);

    // Random traffic against the model
    cycle(1'b1, 1'b0, 128'd0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0, ($urandom_range(0, 2) == 0), {$urandom, $urandom, $urandom, $urandom},
            ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
